clk_rst_sequencer: RTL

Clock/reset bring-up controller for the system clock generator (clk_wiz_1-style PLL/MMCM).
- Runs on the always-on input reference clock.
- Pulses the PLL reset and qualifies its `locked` output.
- Retries on lock timeout and releases the downstream synchronous reset only after a stable lock.
- Re-sequences on lock loss or software request.

Sits between the board reset/clock pins and the clock wizard, and drives the SoC core reset.

---
 rtl/clk_rst_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/clk_rst_sequencer.sv
// Clock/reset bring-up sequencer for a PLL/MMCM clock wizard.
// Pulses the PLL reset, qualifies a synchronized lock, retries on timeout,
// and releases the downstream reset only after a stable lock.
// Optional build macro CLK_SEQ_LOSS_CNT_EN enables the saturating lock-loss counter;
// without it lock_loss_cnt is tied to zero.
module clk_rst_sequencer #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE  = 64,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned REL_DELAY    = 8,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic                               clk_in1,
  input  logic                               resetn,
  input  logic                               locked,
  input  logic                               soft_rst_req,
  output logic                               pll_resetn,
  output logic                               sys_resetn,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
  output logic [2:0]                         state,
  output logic [7:0]                         lock_loss_cnt
);

  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);
  localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
  localparam logic [RW-1:0] RetryMax = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StRelease  = 3'd2,
    StRun      = 3'd3,
    StFault    = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic            locked_meta_q, locked_s_q;
  logic [12:0]     cnt_q, cnt_d;
  logic [SW-1:0]   stab_q, stab_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [RW-1:0]   retry_inc;
  logic            pll_resetn_d, sys_resetn_d, ready_d, fault_d;
  logic            lock_lost, stab_full, rst_done, lock_timeout, rel_done;

  // Two-flop synchronizer for the asynchronous PLL lock flag.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  // Phase conditions; stab_full counts the current cycle so release lands on the Nth locked cycle.
  always_comb begin
    lock_lost    = !locked_s_q && ((state_q == StRelease) || (state_q == StRun));
    stab_full    = locked_s_q && (stab_q == SW'(LOCK_STABLE - 1));
    rst_done     = (cnt_q == 13'(RST_CYCLES - 1));
    lock_timeout = (cnt_q == 13'(LOCK_TIMEOUT - 1));
    rel_done     = (cnt_q == 13'(REL_DELAY - 1));
    retry_inc    = retry_q + RW'(1);
  end

  // State register with phase, stability and retry counters.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      state_q <= StPllRst;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
    end
  end

  // Next-state and counter logic: soft request > lock loss > timeout > normal advance.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    if (soft_rst_req) begin
      state_d = StPllRst;
      if (state_q == StFault) retry_d = '0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (rst_done) state_d = StWaitLock;
        end
        StWaitLock: begin
          if (stab_full) begin
            state_d = StRelease;
          end else if (lock_timeout) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RetryMax) ? StFault : StPllRst;
          end
        end
        StRelease: begin
          if (lock_lost) begin
            state_d = StPllRst;
          end else if (rel_done) begin
            state_d = StRun;
            retry_d = '0;
          end
        end
        StRun: begin
          if (lock_lost) state_d = StPllRst;
        end
        StFault: ;
        default: state_d = StPllRst;
      endcase
    end

    // cnt only advances in timed phases so it cannot wrap while parked in RUN or FAULT.
    if ((state_d != state_q) || soft_rst_req) begin
      cnt_d = '0;
    end else if ((state_q == StPllRst) || (state_q == StWaitLock) || (state_q == StRelease)) begin
      cnt_d = cnt_q + 13'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_q == StWaitLock) && (state_d == StWaitLock) && locked_s_q) begin
      stab_d = stab_q + SW'(1);
    end else begin
      stab_d = '0;
    end
  end

  // Output decode from the next state so outputs change on the entering edge.
  always_comb begin
    pll_resetn_d = !((state_d == StPllRst) || (state_d == StFault));
    sys_resetn_d = (state_d == StRun);
    ready_d      = (state_d == StRun);
    fault_d      = (state_d == StFault);
  end

  // Registered outputs.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      pll_resetn <= 1'b0;
      sys_resetn <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
    end else begin
      pll_resetn <= pll_resetn_d;
      sys_resetn <= sys_resetn_d;
      ready      <= ready_d;
      fault      <= fault_d;
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

`ifdef CLK_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Saturating lock-loss event counter, cleared only by resetn.
  always_ff @(posedge clk_in1 or negedge resetn) begin
    if (!resetn) begin
      loss_q <= 8'd0;
    end else if (lock_lost && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule
